// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the teaching CPU datapath.
// Steps fetch/decode/exec and issues one-hot datapath controls per phase.
module ctrl_sequencer #(
    parameter int OP_W       = 4,
    parameter int IO_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            resume,
    input  logic [OP_W-1:0] instr,
    input  logic            flag_g,
    input  logic            io_ack,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            imm_load,
    output logic            io_req,
    output logic [11:0]     ctrl,
    output logic            halted,
    output logic            illegal,
    output logic            io_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IMM,
        S_IOWAIT,
        S_HALT
    } state_t;

    localparam int B_JMP  = 6;
    localparam int B_JG   = 7;
    localparam int B_IN1  = 8;
    localparam int B_OUT1 = 9;
    localparam int B_MOVI = 10;
    localparam int B_HALT = 11;

    localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

    state_t            state_q, state_d, run_d;
    logic [OP_W-1:0]   ir_q, ir_d;
    logic [11:0]       op_q, op_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              io_err_q, io_err_d;
    logic              ir_load_q, ir_load_d;
    logic              pc_inc_q, pc_inc_d;
    logic              pc_load_q, pc_load_d;
    logic              jg_q, jg_d;
    logic              imm_load_q, imm_load_d;
    logic              io_req_q, io_req_d;
    logic [11:0]       ctrl_q, ctrl_d;
    logic              halted_q, halted_d;
    logic [11:0]       dec;
    logic              dec_bad;
    logic              hi_nz;

    if (OP_W > 4) begin : g_hi
        assign hi_nz = |ir_q[OP_W-1:4];
    end else begin : g_no_hi
        assign hi_nz = 1'b0;
    end

    // Where an instruction boundary goes: keep running or park in IDLE.
    assign run_d = en ? S_FETCH : S_IDLE;

    // Opcode to one-hot control vector; unmapped codes flag illegal.
    always_comb begin
        dec     = '0;
        dec_bad = hi_nz;
        case (ir_q[3:0])
            4'b0100: dec[0]  = 1'b1;
            4'b0101: dec[1]  = 1'b1;
            4'b0110: dec[2]  = 1'b1;
            4'b0111: dec[3]  = 1'b1;
            4'b1000: dec[4]  = 1'b1;
            4'b1001: dec[5]  = 1'b1;
            4'b1010: dec[6]  = 1'b1;
            4'b1011: dec[7]  = 1'b1;
            4'b0000: dec[8]  = 1'b1;
            4'b0001: dec[9]  = 1'b1;
            4'b0010: dec[10] = 1'b1;
            4'b0011: dec[11] = 1'b1;
            default: dec_bad = 1'b1;
        endcase
    end

    // Phase sequencing, I/O wait counting and sticky status.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        io_err_d  = io_err_q;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_bad) begin
                    illegal_d = 1'b1;
                    op_d      = '0;
                    state_d   = S_HALT;
                end else begin
                    op_d    = dec;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    op_q[B_MOVI]:
                        state_d = S_IMM;
                    op_q[B_IN1], op_q[B_OUT1]:
                        state_d = io_ack ? run_d : S_IOWAIT;
                    op_q[B_HALT]:
                        state_d = S_HALT;
                    default:
                        state_d = run_d;
                endcase
            end
            S_IMM: begin
                state_d = run_d;
            end
            S_IOWAIT: begin
                if (io_ack) begin
                    cnt_d   = '0;
                    state_d = run_d;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d    = '0;
                    io_err_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HALT: begin
                if (resume && !illegal_q && !io_err_q)
                    state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output strobes for the state being entered, registered with it.
    always_comb begin
        ir_load_d  = (state_d == S_FETCH);
        pc_inc_d   = (state_d == S_FETCH) || (state_d == S_IMM);
        imm_load_d = (state_d == S_IMM);
        halted_d   = (state_d == S_HALT);
        pc_load_d  = (state_d == S_EXEC) && op_d[B_JMP];
        jg_d       = (state_d == S_EXEC) && op_d[B_JG];
        io_req_d   = (state_d == S_IOWAIT) ||
                     ((state_d == S_EXEC) && (op_d[B_IN1] || op_d[B_OUT1]));
        ctrl_d     = '0;
        if ((state_d == S_EXEC) || (state_d == S_IMM) ||
            (state_d == S_IOWAIT))
            ctrl_d = op_d;
    end

    // State, IR, counter, status and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
            io_err_q   <= 1'b0;
            ir_load_q  <= 1'b0;
            pc_inc_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            jg_q       <= 1'b0;
            imm_load_q <= 1'b0;
            io_req_q   <= 1'b0;
            ctrl_q     <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            io_err_q   <= io_err_d;
            ir_load_q  <= ir_load_d;
            pc_inc_q   <= pc_inc_d;
            pc_load_q  <= pc_load_d;
            jg_q       <= jg_d;
            imm_load_q <= imm_load_d;
            io_req_q   <= io_req_d;
            ctrl_q     <= ctrl_d;
            halted_q   <= halted_d;
        end
    end

    assign ir_load  = ir_load_q;
    assign pc_inc   = pc_inc_q;
    // A jg resolves on the live greater flag during its EXEC cycle.
    assign pc_load  = pc_load_q | (jg_q & flag_g);
    assign imm_load = imm_load_q;
    assign io_req   = io_req_q;
    assign ctrl     = ctrl_q;
    assign halted   = halted_q;
    assign illegal  = illegal_q;
    assign io_err   = io_err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed programs,
// expected strobe events queued by stimulus, popped by a monitor.
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        resume;
    logic [3:0]  instr;
    logic        flag_g;
    logic        io_ack;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic        imm_load;
    logic        io_req;
    logic [11:0] ctrl;
    logic        halted;
    logic        illegal;
    logic        io_err;

    ctrl_sequencer #(
        .OP_W      (4),
        .IO_TIMEOUT(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .resume  (resume),
        .instr   (instr),
        .flag_g  (flag_g),
        .io_ack  (io_ack),
        .ir_load (ir_load),
        .pc_inc  (pc_inc),
        .pc_load (pc_load),
        .imm_load(imm_load),
        .io_req  (io_req),
        .ctrl    (ctrl),
        .halted  (halted),
        .illegal (illegal),
        .io_err  (io_err)
    );

    typedef struct {
        logic [19:0] vec;
        int          gap;
    } exp_t;

    typedef struct packed {
        logic [3:0] op;
        logic       flag;
        logic [3:0] ack;
    } prog_t;

    exp_t  exp_q[$];
    prog_t prog_q[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] obs_vec();
        return {ir_load, pc_inc, pc_load, imm_load, io_req,
                ctrl, halted, illegal, io_err};
    endfunction

    function automatic logic [19:0] mk(bit ir, bit pi, bit pl, bit il,
                                       bit io, bit [11:0] c, bit h,
                                       bit ill, bit ie);
        return {ir, pi, pl, il, io, c, h, ill, ie};
    endfunction

    function automatic void push(logic [19:0] v, int gap);
        exp_t e;
        e.vec = v;
        e.gap = gap;
        exp_q.push_back(e);
    endfunction

    function automatic void ev_fetch(int gap);
        push(mk(1, 1, 0, 0, 0, 12'h000, 0, 0, 0), gap);
    endfunction

    function automatic void ev_exec(bit [11:0] c, bit pl, bit io);
        push(mk(0, 0, pl, 0, io, c, 0, 0, 0), 2);
    endfunction

    function automatic void ev_wait(bit [11:0] c);
        push(mk(0, 0, 0, 0, 1, c, 0, 0, 0), 1);
    endfunction

    function automatic void ev_imm();
        push(mk(0, 1, 0, 1, 0, 12'h400, 0, 0, 0), 1);
    endfunction

    function automatic void ev_halt(bit ill, bit ie, int gap);
        push(mk(0, 0, 0, 0, 0, 12'h000, 1, ill, ie), gap);
    endfunction

    function automatic void add(logic [3:0] op, logic f, logic [3:0] a);
        prog_t p;
        p.op   = op;
        p.flag = f;
        p.ack  = a;
        prog_q.push_back(p);
    endfunction

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Program memory: present the next opcode during each FETCH.
    prog_t      cur;
    logic [3:0] ack_at = '0;
    always @(negedge clk) begin
        if (rst_n && ir_load) begin
            if (prog_q.size() > 0) begin
                cur    = prog_q.pop_front();
                instr  = cur.op;
                flag_g = cur.flag;
                ack_at = cur.ack;
            end else begin
                instr = 4'b0011;
            end
        end
    end

    // I/O device: acknowledge on the ack_at-th requesting cycle.
    int reqcnt = 0;
    always @(negedge clk) begin
        if (io_req) begin
            reqcnt = reqcnt + 1;
            io_ack = (ack_at != 0) && (reqcnt == int'(ack_at));
        end else begin
            reqcnt = 0;
            io_ack = 1'b0;
        end
    end

    // Monitor: every active-strobe cycle or halt entry pops one entry.
    int          cyc = 0;
    int          last = 0;
    logic        prev_h = 1'b0;
    logic [19:0] obs;
    exp_t        e;
    always @(negedge clk) begin
        cyc = cyc + 1;
        obs = obs_vec();
        if (ir_load || pc_inc || pc_load || imm_load || io_req ||
            (ctrl != 12'h000) || (halted && !prev_h)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none",
                         obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e.vec) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", obs, e.vec);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last != e.gap) begin
                        errors++;
                        $display("FAIL latency: got %0d expected %0d",
                                 cyc - last, e.gap);
                    end
                end
            end
            last = cyc;
        end
        prev_h = halted;
    end

    task automatic wait_halted(string name);
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_sb(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_resume();
        @(negedge clk);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        resume = 1'b0;
        instr  = 4'b0000;
        flag_g = 1'b0;
        io_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {12'd0, obs_vec()}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // en dropped during FETCH: instruction completes, then IDLE.
        add(4'b0100, 0, 0);
        ev_fetch(0);
        ev_exec(12'h001, 0, 0);
        en = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ir_load && n < 20);
        end
        en = 1'b0;
        repeat (8) @(negedge clk);
        wait_sb("en_drop_sb");
        chk("en_drop_idle", {30'd0, ir_load, halted}, 32'd0);

        // Main stream: moves, alu, jumps, movi, I/O, halt.
        add(4'b0100, 0, 0);
        add(4'b1000, 0, 0);
        add(4'b1010, 0, 0);
        add(4'b1011, 0, 0);
        add(4'b1011, 1, 0);
        add(4'b0010, 0, 0);
        add(4'b0001, 0, 4);
        add(4'b0000, 0, 1);
        add(4'b0011, 0, 0);
        ev_fetch(0);
        ev_exec(12'h001, 0, 0);
        ev_fetch(1);
        ev_exec(12'h010, 0, 0);
        ev_fetch(1);
        ev_exec(12'h040, 1, 0);
        ev_fetch(1);
        ev_exec(12'h080, 0, 0);
        ev_fetch(1);
        ev_exec(12'h080, 1, 0);
        ev_fetch(1);
        ev_exec(12'h400, 0, 0);
        ev_imm();
        ev_fetch(1);
        ev_exec(12'h200, 0, 1);
        ev_wait(12'h200);
        ev_wait(12'h200);
        ev_wait(12'h200);
        ev_fetch(1);
        ev_exec(12'h100, 0, 1);
        ev_fetch(1);
        ev_exec(12'h800, 0, 0);
        ev_halt(0, 0, 1);
        @(negedge clk);
        en = 1'b1;
        wait_halted("stream_halt");
        wait_sb("stream_sb");

        // Resume from HALT: FETCH on the very next cycle.
        add(4'b0100, 0, 0);
        add(4'b0011, 0, 0);
        ev_fetch(0);
        ev_exec(12'h001, 0, 0);
        ev_fetch(1);
        ev_exec(12'h800, 0, 0);
        ev_halt(0, 0, 1);
        pulse_resume();
        chk("resume_fetch", {31'd0, ir_load}, 32'd1);
        #1;
        wait_halted("resume_halt");
        wait_sb("resume_sb");

        // I/O timeout: no ack within 4 IOWAIT cycles.
        add(4'b0001, 0, 0);
        ev_fetch(0);
        ev_exec(12'h200, 0, 1);
        ev_wait(12'h200);
        ev_wait(12'h200);
        ev_wait(12'h200);
        ev_wait(12'h200);
        ev_halt(0, 1, 1);
        pulse_resume();
        #1;
        wait_halted("timeout_halt");
        wait_sb("timeout_sb");
        chk("timeout_flags", {29'd0, io_req, io_err, halted}, 32'd3);
        pulse_resume();
        repeat (4) @(negedge clk);
        chk("timeout_resume_ign", {30'd0, halted, io_err}, 32'd3);

        // Reset asserted in the middle of IOWAIT.
        rst_n = 1'b0;
        #1;
        chk("reset_clears_ioerr", {31'd0, io_err}, 32'd0);
        add(4'b0000, 0, 0);
        ev_fetch(0);
        ev_exec(12'h100, 0, 1);
        ev_wait(12'h100);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sb("iowait_sb");
        #2;
        chk("pre_reset_ioreq", {31'd0, io_req}, 32'd1);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_reset_out", {12'd0, obs_vec()}, 32'd0);

        // Illegal opcode: sticky, resume ignored.
        @(negedge clk);
        prog_q.delete();
        add(4'b1100, 0, 0);
        ev_fetch(0);
        ev_halt(1, 0, 2);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_halted("illegal_halt");
        wait_sb("illegal_sb");
        pulse_resume();
        repeat (4) @(negedge clk);
        chk("illegal_sticky", {19'd0, halted, illegal, ctrl}, 32'h2000 | 32'h1000);
        rst_n = 1'b0;
        #1;
        chk("illegal_reset", {30'd0, illegal, halted}, 32'd0);
        repeat (2) @(negedge clk);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer replacing the purely combinational opcode decoder in the teaching CPU datapath. Steps each instruction through fetch, decode and execute phases and issues the one-hot datapath controls in the correct phase. Adds an immediate-fetch phase for `movi`, an I/O handshake with timeout, conditional `jg` resolution, and sticky halt/illegal/error status. Sits between program memory/IR and the register file, ALU, PC and I/O ports.

## Interface
- `OP_W`, 4, opcode width; must be ≥ 4. Bits above [3:0] must be zero, otherwise the opcode is illegal.
- `IO_TIMEOUT`, 16, maximum number of I/O wait cycles before an error; range 1..255.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: run enable.
- `resume` in 1: one-cycle pulse that leaves HALT. Ignored while `illegal` or `io_err` is set.
- `instr` in OP_W: opcode from program memory; valid in the cycle `ir_load`=1.
- `flag_g` in 1: ALU greater flag; sampled in EXEC of `jg`.
- `io_ack` in 1: I/O device acknowledge.
- `ir_load` out 1: latch `instr` (FETCH).
- `pc_inc` out 1: increment PC (FETCH, IMM).
- `pc_load` out 1: load PC from operand bus (EXEC of `jmp`, or taken `jg`).
- `imm_load` out 1: latch immediate operand (IMM).
- `io_req` out 1: I/O request, held while waiting.
- `ctrl` out 12: one-hot controls. Bit order: 0 `mova`, 1 `movb`, 2 `movc`, 3 `movd`, 4 `add`, 5 `sub`, 6 `jmp`, 7 `jg`, 8 `in1`, 9 `out1`, 10 `movi`, 11 `halt`.
- `halted` out 1: in HALT state.
- `illegal` out 1: sticky illegal-opcode flag.
- `io_err` out 1: sticky I/O timeout flag.

## Operation
- Opcode map on `instr[3:0]`:
  - 0100 `mova`, 0101 `movb`, 0110 `movc`, 0111 `movd`
  - 1000 `add`, 1001 `sub`, 1010 `jmp`, 1011 `jg`
  - 0000 `in1`, 0001 `out1`, 0010 `movi`, 0011 `halt`
  - 11xx, or any nonzero bit in [OP_W-1:4], is illegal.
- States: IDLE, FETCH, DECODE, EXEC, IMM, IOWAIT, HALT.
- IDLE: all outputs 0. Goes to FETCH when `en`=1.
- FETCH: `ir_load`=1, `pc_inc`=1. Opcode registered into IR. Next state DECODE.
- DECODE: IR decoded into a registered one-hot vector; no outputs asserted.
  - Illegal opcode: set `illegal`, go to HALT.
  - Otherwise go to EXEC.
- EXEC: exactly one `ctrl` bit = 1.
  - `jmp`: `pc_load`=1.
  - `jg`: `pc_load`=`flag_g`.
  - `movi`: next state IMM.
  - `in1`/`out1`: `io_req`=1; next state IOWAIT, or FETCH if `io_ack`=1 in this cycle.
  - `halt`: next state HALT.
  - All others: next state FETCH, or IDLE if `en`=0.
- IMM: `ctrl[10]`=1, `pc_inc`=1, `imm_load`=1. Next state FETCH, or IDLE if `en`=0.
- IOWAIT: `ctrl` bit and `io_req` held. A wait counter counts IOWAIT cycles.
  - `io_ack`=1: go to FETCH (or IDLE if `en`=0).
  - Counter reaches `IO_TIMEOUT` without ack: set `io_err`, drop `io_req`, go to HALT.
- HALT: `halted`=1, all other strobes 0. Leaves to FETCH only on `resume`=1 with both `illegal` and `io_err` clear.
- `en` falling mid-instruction: the current instruction completes; the sequencer stops at the next FETCH boundary (enters IDLE instead of FETCH).
- `resume` outside HALT is ignored.
- `illegal` and `io_err` clear only on reset.

## Timing
- Reset: state IDLE. `ctrl`=0, `ir_load`=`pc_inc`=`pc_load`=`imm_load`=`io_req`=0, `halted`=`illegal`=`io_err`=0. Wait counter = 0.
- All outputs are registered-state Moore decodes, except `pc_load` for `jg` (follows `flag_g` combinationally in EXEC) and the EXEC→FETCH shortcut on `io_ack`.
- Latency, FETCH to next FETCH:
  - Plain ops: 3 cycles.
  - `movi`: 4 cycles.
  - `in1`/`out1`: 3 + N cycles, where N = IOWAIT cycles before ack.
- Timeout: `io_err` rises on the clock edge after the `IO_TIMEOUT`-th IOWAIT cycle with no ack.
- `io_ack` is meaningful only while `io_req`=1; ignored otherwise.
- `en` is sampled only at the EXEC/IMM/IOWAIT exit and in IDLE.

## Test plan
- Reset, `en`=1, stream 0100,1000,1010: `ir_load` pulses every 3 cycles; `ctrl` = 0x001, 0x010, 0x040 in successive EXEC cycles; `pc_load`=1 only for 1010.
- `jg` (1011) with `flag_g`=0, then 1011 with `flag_g`=1: `pc_load` = 0 then 1; `ctrl[7]`=1 in both EXEC cycles.
- `movi` (0010): EXEC `ctrl`=0x400, then IMM with `pc_inc`=`imm_load`=1; next `ir_load` arrives 4 cycles after the previous one.
- `out1` (0001), `io_ack` after 3 cycles: `io_req` and `ctrl[9]` held 4 cycles, then FETCH. Repeat with `IO_TIMEOUT`=4 and no ack: `io_err`=1, `halted`=1, `io_req`=0.
- Opcode 1100: `illegal`=1, `halted`=1, `ctrl` never nonzero; `resume` ignored until `rst_n` low.
- `halt` (0011) then `resume` pulse: `ctrl`=0x800 for one cycle, then `halted`=1; after `resume`, FETCH on the next cycle. Assert `rst_n` low mid-IOWAIT: all outputs 0 immediately.
